eth_phy_10g_rx_ber_monitor: RTL
===============================

// Module: eth_phy_10g_rx_ber_monitor
// PURPOSE
//  - 10GBASE-R RX bit-error-rate monitor (IEEE 802.3 cl.49 hi_ber function), directly downstream of the RX frame aligner.
//  - Consumes the aligner's 2-bit sync header and block-lock flag each clk.
//  - Counts invalid sync headers (2'b00 / 2'b11) in a fixed time window; raises o_rx_high_ber when count reaches threshold.
//  - o_rx_high_ber feeds the RX link-status logic and the decoder error path.
// PARAMETERS
//  HDR_WIDTH     2      sync header width; fixed at 2.
//  TIMER_CYCLES  19531  window length in clk cycles (125 us @ 156.25 MHz); min 2.
//  BER_THRESH    16     invalid headers per window that set hi_ber; 1..63.
//  ERR_CNT_WIDTH 16     width of cumulative error counter (BER_ERR_CNT_EN only).
// PORTS
//  clk                  in   1              RX clock.
//  rst                  in   1              synchronous reset, active-low.
//  i_serdes_rx_hdr      in   HDR_WIDTH      sync header from aligner, valid every cycle.
//  i_rx_block_lock      in   1              block lock from aligner.
//  o_rx_high_ber        out  1              high BER indication, registered.
//  o_ber_cnt            out  6              invalid headers seen in current window, saturates at BER_THRESH.
//  i_err_cnt_clr        in   1              clear cumulative counter (BER_ERR_CNT_EN only).
//  o_ber_err_cnt        out  ERR_CNT_WIDTH  cumulative invalid headers (BER_ERR_CNT_EN only).
// BEHAVIOUR
//  - Reset (rst==0 at posedge clk): state=INIT, timer=0, o_ber_cnt=0, o_rx_high_ber=0, o_ber_err_cnt=0.
//  - Invalid header: i_serdes_rx_hdr in {2'b00, 2'b11}; 2'b01/2'b10 valid.
//  - FSM states: INIT, TEST, HI_BER.
//    INIT: timer=0, cnt=0, hi_ber=0. -> TEST when i_rx_block_lock==1.
//    TEST: timer increments each cycle; invalid header increments cnt (saturate BER_THRESH).
//      cnt reaching BER_THRESH -> HI_BER; o_rx_high_ber=1 on the clk after the sampling edge of the BER_THRESH-th bad header.
//      timer==TIMER_CYCLES-1 (window end) with cnt<BER_THRESH: o_rx_high_ber<=0, cnt<=0, timer<=0, stay TEST.
//    HI_BER: o_rx_high_ber held 1; timer keeps running; bad headers not counted beyond saturation.
//      at window end: cnt<=0, timer<=0 -> TEST; o_rx_high_ber stays 1 until a later window ends with cnt<BER_THRESH.
//  - Simultaneous bad header + window end: header belongs to the expiring window (counted and compared), new window starts with cnt=0.
//  - Block lock lost (i_rx_block_lock==0) in any state: next cycle -> INIT; o_rx_high_ber<=0, cnt<=0, timer<=0.
//    Header on the cycle lock drops is ignored.
//  - Threshold crossing mid-window is immediate; clearing happens only at window ends.
//  - Timer width $clog2(TIMER_CYCLES); wraps only via explicit window-end reset, never by overflow.
//  - All outputs registered; no combinational input->output path.
// CONFIGURATION
//  - Macro BER_ERR_CNT_EN:
//    defined: i_err_cnt_clr, o_ber_err_cnt present; counter += 1 per invalid header while i_rx_block_lock==1,
//      saturates at all-ones, independent of window/FSM; i_err_cnt_clr==1 clears it to 0 next cycle
//      (clear wins over a simultaneous increment); reset clears it.
//    undefined: both ports and the counter logic absent; remaining behaviour identical.
// STRUCTURE
//  - Shared include eth_phy_10g_defs.vh: SYNC_DATA=2'b01, SYNC_CTRL=2'b10, HDR_WIDTH, default TIMER_CYCLES/BER_THRESH, FSM state encodings.
//  - One sub-module: eth_phy_10g_window_timer (free-running counter, param TIMER_CYCLES, sync clear, o_expire pulse at TIMER_CYCLES-1).
//  - FSM, saturating counters and optional error counter in this module.
// TESTING (bench uses TIMER_CYCLES=100, BER_THRESH=4 unless noted)
//  1. Lock=1, headers alternate 01/10 for 500 cycles -> o_rx_high_ber==0, o_ber_cnt==0 throughout.
//  2. Lock=1, 4 headers 2'b00 at cycles 10..13 of a window -> o_rx_high_ber==1 at cycle 14, held until end of next clean window, then 0.
//  3. 3 bad headers per window, repeated 5 windows -> o_rx_high_ber never asserts; o_ber_cnt returns to 0 each window end.
//  4. 3rd bad header at cycle 97, 4th on window-end cycle 99 -> o_rx_high_ber==1; next window starts with o_ber_cnt==0.
//  5. In HI_BER, drop i_rx_block_lock for 1 cycle -> next cycle o_rx_high_ber==0, o_ber_cnt==0; relock restarts window from timer 0.
//  6. BER_ERR_CNT_EN, ERR_CNT_WIDTH=4: 20 bad headers -> o_ber_err_cnt==15 (saturated); i_err_cnt_clr with bad header -> 0.
//  - Default params: 16 bad headers within 19531 cycles asserts; 15 does not; rst==0 mid-HI_BER clears all outputs next cycle.

Source files
------------

// File: rtl/eth_phy_10g_rx_ber_monitor_pkg.sv
// ---------------------------------------------------------------------------
// eth_phy_10g_rx_ber_monitor_pkg
// Shared definitions for the 10GBASE-R RX BER monitor:
//   - sync header width and the two valid sync header codes
//   - default window length / threshold / error counter width
//   - hi_ber FSM state encoding
//   - hdr_invalid(): classifies a sync header as invalid (2'b00 / 2'b11)
// ---------------------------------------------------------------------------
package eth_phy_10g_rx_ber_monitor_pkg;

  localparam int SYNC_HDR_WIDTH = 2;

  localparam logic [SYNC_HDR_WIDTH-1:0] SYNC_DATA = 2'b01;
  localparam logic [SYNC_HDR_WIDTH-1:0] SYNC_CTRL = 2'b10;

  // 125 us at 156.25 MHz
  localparam int DEF_TIMER_CYCLES  = 19531;
  localparam int DEF_BER_THRESH    = 16;
  localparam int DEF_ERR_CNT_WIDTH = 16;

  // Window counter width; wide enough for thresholds up to 63.
  localparam int BER_CNT_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_TEST   = 2'd1,
    ST_HI_BER = 2'd2
  } ber_state_e;

  function automatic logic hdr_invalid(input logic [SYNC_HDR_WIDTH-1:0] hdr);
    return !((hdr == SYNC_DATA) || (hdr == SYNC_CTRL));
  endfunction

endpackage

// File: rtl/eth_phy_10g_window_timer.sv
// ---------------------------------------------------------------------------
// eth_phy_10g_window_timer
// Free-running window counter for the BER monitor. Counts 0..TIMER_CYCLES-1
// and restarts at 0; never relies on natural overflow.
//
// Ports:
//   clk       in  RX clock
//   rst       in  synchronous reset, active-low (count -> 0)
//   i_clr     in  synchronous clear; holds the count at 0 while asserted
//   o_expire  out 1 on the last cycle of a window (count == TIMER_CYCLES-1)
// ---------------------------------------------------------------------------
module eth_phy_10g_window_timer #(
  parameter int TIMER_CYCLES = 19531
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_expire
);

  localparam int            TW   = (TIMER_CYCLES > 1) ? $clog2(TIMER_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMER_CYCLES - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;
  logic          at_last;

  assign at_last  = (count_q == LAST);
  assign o_expire = at_last && !i_clr;

  always_comb begin
    count_d = count_q + TW'(1);
    if (i_clr || at_last) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/eth_phy_10g_rx_ber_monitor.sv
// ---------------------------------------------------------------------------
// eth_phy_10g_rx_ber_monitor
// 10GBASE-R RX hi_ber monitor. Counts invalid sync headers (2'b00 / 2'b11)
// inside fixed windows of TIMER_CYCLES clocks and raises o_rx_high_ber as
// soon as BER_THRESH of them are seen within one window. The flag is only
// dropped at the end of a window that stayed below the threshold.
//
// Optional feature macro: BER_ERR_CNT_EN
//   defined   -> i_err_cnt_clr / o_ber_err_cnt and a saturating cumulative
//                invalid-header counter (parameter ERR_CNT_WIDTH)
//   undefined -> those ports and the counter are absent
//
// Ports:
//   clk              in   RX clock
//   rst              in   synchronous reset, active-low
//   i_serdes_rx_hdr  in   sync header from the frame aligner, every cycle
//   i_rx_block_lock  in   block lock from the frame aligner
//   i_err_cnt_clr    in   clear cumulative counter (BER_ERR_CNT_EN)
//   o_ber_err_cnt    out  cumulative invalid headers (BER_ERR_CNT_EN)
//   o_rx_high_ber    out  high BER flag, registered
//   o_ber_cnt        out  invalid headers in current window, saturates at
//                         BER_THRESH, registered
//
// FSM states:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_INIT   | no block lock (or just reset); timer and count held at 0
//   ST_TEST   | window running, count below threshold
//   ST_HI_BER | threshold reached in the current window; flag held at 1
// ---------------------------------------------------------------------------
module eth_phy_10g_rx_ber_monitor
  import eth_phy_10g_rx_ber_monitor_pkg::*;
#(
  parameter int HDR_WIDTH     = SYNC_HDR_WIDTH,
  parameter int TIMER_CYCLES  = DEF_TIMER_CYCLES,
  parameter int BER_THRESH    = DEF_BER_THRESH
`ifdef BER_ERR_CNT_EN
  ,
  parameter int ERR_CNT_WIDTH = DEF_ERR_CNT_WIDTH
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [HDR_WIDTH-1:0]     i_serdes_rx_hdr,
  input  logic                     i_rx_block_lock,
`ifdef BER_ERR_CNT_EN
  input  logic                     i_err_cnt_clr,
  output logic [ERR_CNT_WIDTH-1:0] o_ber_err_cnt,
`endif
  output logic                     o_rx_high_ber,
  output logic [BER_CNT_WIDTH-1:0] o_ber_cnt
);

  localparam logic [BER_CNT_WIDTH-1:0] THRESH = BER_CNT_WIDTH'(BER_THRESH);

  ber_state_e               state_q, state_d;
  logic [BER_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     hi_ber_q, hi_ber_d;

  logic                     hdr_bad;
  logic                     win_end;
  logic                     tmr_clr;
  logic [BER_CNT_WIDTH-1:0] cnt_inc;

  assign hdr_bad = hdr_invalid(i_serdes_rx_hdr);

  // The window only runs while locked and out of INIT, so the first TEST
  // cycle after (re)lock always sees timer position 0.
  assign tmr_clr = !i_rx_block_lock || (state_q == ST_INIT);

  eth_phy_10g_window_timer #(
    .TIMER_CYCLES (TIMER_CYCLES)
  ) u_window_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (tmr_clr),
    .o_expire (win_end)
  );

  // Count this cycle's header, saturating at the threshold.
  assign cnt_inc = (hdr_bad && (cnt_q != THRESH)) ? (cnt_q + BER_CNT_WIDTH'(1)) : cnt_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_ber_d = hi_ber_q;

    if (!i_rx_block_lock) begin
      state_d  = ST_INIT;
      cnt_d    = '0;
      hi_ber_d = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          state_d  = ST_TEST;
          cnt_d    = '0;
          hi_ber_d = 1'b0;
        end

        ST_TEST: begin
          if (win_end) begin
            // A bad header on the last cycle still belongs to this window.
            state_d  = ST_TEST;
            cnt_d    = '0;
            hi_ber_d = (cnt_inc == THRESH);
          end else if (cnt_inc == THRESH) begin
            state_d  = ST_HI_BER;
            cnt_d    = cnt_inc;
            hi_ber_d = 1'b1;
          end else begin
            cnt_d    = cnt_inc;
          end
        end

        ST_HI_BER: begin
          hi_ber_d = 1'b1;
          if (win_end) begin
            // Flag stays up; the following window decides whether it clears.
            state_d = ST_TEST;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_inc;
          end
        end

        default: begin
          state_d  = ST_INIT;
          cnt_d    = '0;
          hi_ber_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      hi_ber_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_ber_q <= hi_ber_d;
    end
  end

  assign o_rx_high_ber = hi_ber_q;
  assign o_ber_cnt     = cnt_q;

`ifdef BER_ERR_CNT_EN
  // Cumulative count runs independently of the window FSM; clear has
  // priority over a same-cycle increment.
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (i_err_cnt_clr) begin
      err_cnt_d = '0;
    end else if (i_rx_block_lock && hdr_bad && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_ber_err_cnt = err_cnt_q;
`endif

endmodule
